// File: rtl/instruction_fetch_unit.sv
// Fetch PC generator with a memory request/ack handshake and an output entry
// backed by a one-deep skid entry. Redirects kill wrong-path fetches, including one still in flight.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] PC
);

  typedef enum logic {REQ, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_pc_q, kill_pc_d;

  logic        consume;
  logic [31:0] target;

  assign consume = out_valid_q && !Stall;
  assign target  = RedirectPC & 32'hFFFF_FFFC;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      kill_q       <= 1'b0;
      kill_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      kill_q       <= kill_d;
      kill_pc_q    <= kill_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_valid_d  = out_valid_q && !consume;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    kill_d       = kill_q;
    kill_pc_d    = kill_pc_q;

    case (state_q)
      REQ: begin
        if (!MemAck) begin
          // The in-flight address must not move; remember where to go once it lands.
          if (RedirectValid) begin
            kill_d      = 1'b1;
            kill_pc_d   = target;
            out_valid_d = 1'b0;
          end
        end else if (kill_q || RedirectValid) begin
          pc_d   = RedirectValid ? target : kill_pc_q;
          kill_d = 1'b0;
          if (RedirectValid) out_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
          out_valid_d = 1'b1;
          out_instr_d = MemData;
          out_pc_d    = pc_q;
          pc_d        = pc_q + 32'd4;
        end else begin
          skid_instr_d = MemData;
          skid_pc_d    = pc_q;
          pc_d         = pc_q + 32'd4;
          state_d      = FULL;
        end
      end
      FULL: begin
        if (RedirectValid) begin
          out_valid_d  = 1'b0;
          skid_instr_d = '0;
          skid_pc_d    = '0;
          pc_d         = target;
          state_d      = REQ;
        end else if (consume) begin
          out_valid_d = 1'b1;
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          state_d     = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  assign MemReq     = (state_q == REQ) && !Reset;
  assign MemAddr    = pc_q;
  assign PC         = pc_q;
  assign InstrValid = out_valid_q;
  assign Instr      = out_instr_q;
  assign InstrPC    = out_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a per-cycle vector table plus
// hand-written redirect, skid-flush and reset-abandon sequences.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] PC;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t tbl[$];

  instruction_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall),
    .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC), .PC(PC)
  );

  always #5 Clock = ~Clock;

  // Memory image: each word differs from its address so data and PC paths are distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  assign MemData = MemAck ? mem_word(MemAddr) : 32'hDEAD_BEEF;

  function automatic vec_t v(input logic rst, input logic stall, input logic rv,
                             input logic [31:0] rpc, input logic ack, input logic req,
                             input logic [31:0] addr, input logic iv, input logic [31:0] ipc);
    vec_t r;
    r.rst = rst; r.stall = stall; r.rv = rv; r.rpc = rpc; r.ack = ack;
    r.exp_req = req; r.exp_addr = addr; r.exp_iv = iv; r.exp_ipc = ipc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs at the falling edge, advance past the rising edge.
  task automatic step(input string tag, input vec_t r);
    Reset = r.rst; Stall = r.stall; RedirectValid = r.rv; RedirectPC = r.rpc; MemAck = r.ack;
    @(negedge Clock);
    chk({tag, "_req"},  {31'd0, MemReq}, {31'd0, r.exp_req});
    chk({tag, "_addr"}, MemAddr, r.exp_addr);
    chk({tag, "_pc"},   PC, r.exp_addr);
    chk({tag, "_iv"},   {31'd0, InstrValid}, {31'd0, r.exp_iv});
    if (r.exp_iv) begin
      chk({tag, "_ipc"},   InstrPC, r.exp_ipc);
      chk({tag, "_instr"}, Instr, mem_word(r.exp_ipc));
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1; Stall = 1'b0; RedirectValid = 1'b0; RedirectPC = '0; MemAck = 1'b0;
    @(posedge Clock);
    #1;
    step(tag, v(1, 0, 0, 0, 0, 0, 32'h3000, 0, 0));
  endtask

  initial begin
    // Zero-wait stream, 3-cycle stall with skid capture, reset, 2-wait-state stream, in-flight redirect.
    tbl.push_back(v(1,0,0,0,0, 0,32'h3000,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,32'h3000,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,32'h3004,1,32'h3000));
    tbl.push_back(v(0,1,0,0,1, 1,32'h3008,1,32'h3004));
    tbl.push_back(v(0,1,0,0,0, 0,32'h300C,1,32'h3004));
    tbl.push_back(v(0,1,0,0,0, 0,32'h300C,1,32'h3004));
    tbl.push_back(v(0,0,0,0,0, 0,32'h300C,1,32'h3004));
    tbl.push_back(v(0,0,0,0,1, 1,32'h300C,1,32'h3008));
    tbl.push_back(v(0,0,0,0,1, 1,32'h3010,1,32'h300C));
    tbl.push_back(v(0,0,0,0,0, 1,32'h3014,1,32'h3010));
    tbl.push_back(v(0,0,0,0,0, 1,32'h3014,0,0));
    tbl.push_back(v(1,0,0,0,0, 0,32'h3014,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,32'h3000,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,32'h3000,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,32'h3000,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,32'h3004,1,32'h3000));
    tbl.push_back(v(0,0,0,0,0, 1,32'h3004,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,32'h3004,0,0));
    tbl.push_back(v(0,1,1,32'h4003,0, 1,32'h3008,1,32'h3004));
    tbl.push_back(v(0,0,0,0,0, 1,32'h3008,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,32'h3008,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,32'h4000,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,32'h4000,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,32'h4000,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,32'h4004,1,32'h4000));

    Reset = 1'b1; Stall = 1'b0; RedirectValid = 1'b0; RedirectPC = '0; MemAck = 1'b0;
    @(posedge Clock);
    #1;
    foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

    // Redirect to the top of the address space while output and skid are both full.
    do_reset("full_rst");
    step("full_a", v(0,0,0,0,1, 1,32'h3000,0,0));
    step("full_b", v(0,0,0,0,1, 1,32'h3004,1,32'h3000));
    step("full_c", v(0,1,0,0,1, 1,32'h3008,1,32'h3004));
    step("full_d", v(0,1,1,32'hFFFF_FFFC,0, 0,32'h300C,1,32'h3004));
    step("full_e", v(0,0,0,0,0, 1,32'hFFFF_FFFC,0,0));
    step("full_f", v(0,0,0,0,1, 1,32'hFFFF_FFFC,0,0));
    step("full_g", v(0,0,0,0,0, 1,32'h0000_0000,1,32'hFFFF_FFFC));

    // Two redirects during one pending fetch (latest wins), then a redirect coinciding with an ack.
    do_reset("multi_rst");
    step("multi_a", v(0,0,1,32'h5000,0, 1,32'h3000,0,0));
    step("multi_b", v(0,0,1,32'h6008,0, 1,32'h3000,0,0));
    step("multi_c", v(0,0,0,0,1, 1,32'h3000,0,0));
    step("multi_d", v(0,0,1,32'h7000,1, 1,32'h6008,0,0));
    step("multi_e", v(0,0,0,0,1, 1,32'h7000,0,0));
    step("multi_f", v(0,0,0,0,0, 1,32'h7004,1,32'h7000));

    // Reset during a wait-state fetch of 0x3010 with a stale ack arriving in the reset cycle.
    do_reset("mid_rst");
    step("mid_a", v(0,0,0,0,1, 1,32'h3000,0,0));
    step("mid_b", v(0,0,0,0,1, 1,32'h3004,1,32'h3000));
    step("mid_c", v(0,0,0,0,1, 1,32'h3008,1,32'h3004));
    step("mid_d", v(0,0,0,0,1, 1,32'h300C,1,32'h3008));
    step("mid_e", v(0,0,0,0,0, 1,32'h3010,1,32'h300C));
    step("mid_f", v(1,0,0,0,1, 0,32'h3010,0,0));
    step("mid_g", v(1,0,0,0,0, 0,32'h3000,0,0));
    step("mid_h", v(0,0,0,0,0, 1,32'h3000,0,0));
    step("mid_i", v(0,0,0,0,1, 1,32'h3000,0,0));
    step("mid_j", v(0,0,0,0,0, 1,32'h3004,1,32'h3000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
